// File: rtl/pcie_dma_pkg.sv
// Shared types and constants for the PCIe EP request / DMA datapath.
package pcie_dma_pkg;

   localparam int unsigned PCIE_REQ_DBITS = 73;

   // One request word as carried between the EP request path and the DMA engine.
   typedef struct packed {
      logic                      last;
      logic [PCIE_REQ_DBITS-1:0] data;
   } pcie_req_word_t;

endpackage : pcie_dma_pkg

// File: rtl/pcie_req_pkt_fifo_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module pcie_req_pkt_fifo_ram #(
   parameter int unsigned aw = 2,
   parameter int unsigned w  = 74
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [aw-1:0] i_waddr,
   input  logic [w-1:0]  i_wdata,
   input  logic [aw-1:0] i_raddr,
   output logic [w-1:0]  o_rdata
);

   localparam int unsigned DEPTH = 2 ** aw;

   logic [w-1:0] mem_q [DEPTH];

   // Write port; contents carry no reset since the pointers define validity.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule : pcie_req_pkt_fifo_ram

// File: rtl/pcie_req_pkt_fifo.sv
// Single-clock packet FIFO: words become visible only once their packet's last
// word is written; aborted or overflowing packets are rolled back.
module pcie_req_pkt_fifo
   import pcie_dma_pkg::*;
#(
   parameter int unsigned abits     = 2,
   parameter int unsigned dbits     = PCIE_REQ_DBITS,
   parameter int unsigned afull_lvl = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr,
   input  logic [dbits-1:0] i_wdata,
   input  logic             i_wlast,
   input  logic             i_wdrop,
   output logic             o_wfull,
   output logic             o_wafull,
   output logic [abits:0]   o_wcount,
   output logic             o_ovf,
   input  logic             i_rd,
   output logic [dbits-1:0] o_rdata,
   output logic             o_rlast,
   output logic             o_rempty
);

   localparam int unsigned PW    = abits + 1;
   localparam int unsigned DEPTH = 2 ** abits;
   localparam int unsigned WW    = dbits + 1;

   // Writer state: accepting words, or discarding the rest of an overflowed packet.
   localparam logic [0:0] ST_PASS    = 1'b0;
   localparam logic [0:0] ST_DISCARD = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] cm_ptr_q, cm_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;

   logic [PW-1:0] wcount_c;
   logic          wfull_c;
   logic          rempty_c;
   logic          ram_we_c;
   logic [WW-1:0] ram_rdata_c;

   // Occupancy and flags derived from the pointers.
   assign wcount_c = wr_ptr_q - rd_ptr_q;
   assign wfull_c  = (wcount_c == PW'(DEPTH));
   assign rempty_c = (cm_ptr_q == rd_ptr_q);

   // Next-state logic for the writer state, pointers and overflow pulse.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      cm_ptr_d = cm_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = 1'b0;
      ram_we_c = 1'b0;

      if (i_wdrop) begin
         // Abort wins over any same-cycle write.
         wr_ptr_d = cm_ptr_q;
         state_d  = ST_PASS;
      end else if (i_wr) begin
         if (state_q == ST_DISCARD || wfull_c) begin
            if (i_wlast) begin
               wr_ptr_d = cm_ptr_q;
               state_d  = ST_PASS;
               ovf_d    = 1'b1;
            end else begin
               state_d  = ST_DISCARD;
            end
         end else begin
            ram_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (i_wlast) begin
               cm_ptr_d = wr_ptr_q + PW'(1);
            end
         end
      end

      if (i_rd && !rempty_c) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // State and pointer registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_PASS;
         wr_ptr_q <= '0;
         cm_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         cm_ptr_q <= cm_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   pcie_req_pkt_fifo_ram #(
      .aw (abits),
      .w  (WW)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (ram_we_c),
      .i_waddr (wr_ptr_q[abits-1:0]),
      .i_wdata ({i_wlast, i_wdata}),
      .i_raddr (rd_ptr_q[abits-1:0]),
      .o_rdata (ram_rdata_c)
   );

   assign o_wcount = wcount_c;
   assign o_wfull  = wfull_c;
   assign o_wafull = (wcount_c >= PW'(afull_lvl));
   assign o_rempty = rempty_c;
   assign o_ovf    = ovf_q;
   assign o_rdata  = ram_rdata_c[dbits-1:0];
   // Masked while empty so the flag never reflects stale or unwritten storage.
   assign o_rlast  = ram_rdata_c[dbits] & ~rempty_c;

endmodule : pcie_req_pkt_fifo

// File: tb/tb_pcie_req_pkt_fifo.sv
// Self-checking bench for pcie_req_pkt_fifo against a queue-based packet model.
module tb_pcie_req_pkt_fifo;
   import pcie_dma_pkg::*;

   localparam int unsigned ABITS = 2;
   localparam int unsigned DBITS = 73;
   localparam int unsigned AFULL = 3;
   localparam int unsigned DEPTH = 4;

   logic             clk = 1'b0;
   logic             i_rst = 1'b0;
   logic             i_wr = 1'b0;
   logic [DBITS-1:0] i_wdata = '0;
   logic             i_wlast = 1'b0;
   logic             i_wdrop = 1'b0;
   logic             i_rd = 1'b0;
   logic             o_wfull, o_wafull, o_ovf, o_rlast, o_rempty;
   logic [ABITS:0]   o_wcount;
   logic [DBITS-1:0] o_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: committed-but-unread words, pending (uncommitted) words, discard flag.
   pcie_req_word_t m_c[$];
   pcie_req_word_t m_p[$];
   bit             m_err = 1'b0;
   bit             m_ovf = 1'b0;

   always #5 clk = ~clk;

   pcie_req_pkt_fifo #(
      .abits     (ABITS),
      .dbits     (DBITS),
      .afull_lvl (AFULL)
   ) dut (
      .i_clk    (clk),
      .i_rst    (i_rst),
      .i_wr     (i_wr),
      .i_wdata  (i_wdata),
      .i_wlast  (i_wlast),
      .i_wdrop  (i_wdrop),
      .o_wfull  (o_wfull),
      .o_wafull (o_wafull),
      .o_wcount (o_wcount),
      .o_ovf    (o_ovf),
      .i_rd     (i_rd),
      .o_rdata  (o_rdata),
      .o_rlast  (o_rlast),
      .o_rempty (o_rempty)
   );

   function automatic int m_occ();
      return m_c.size() + m_p.size();
   endfunction

   // Apply one clock of writer/reader activity to the packet model.
   task automatic model_apply(input bit wr, input logic [DBITS-1:0] d, input bit last,
                              input bit drop, input bit rd);
      bit full, empty;
      pcie_req_word_t w;
      full  = (m_occ() == int'(DEPTH));
      empty = (m_c.size() == 0);
      m_ovf = 1'b0;
      if (drop) begin
         m_p.delete();
         m_err = 1'b0;
      end else if (wr) begin
         if (m_err || full) begin
            if (last) begin
               m_p.delete();
               m_err = 1'b0;
               m_ovf = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end else begin
            w.last = last;
            w.data = d;
            m_p.push_back(w);
            if (last) begin
               while (m_p.size() > 0) m_c.push_back(m_p.pop_front());
            end
         end
      end
      if (rd && !empty) void'(m_c.pop_front());
   endtask

   // Drive one cycle of inputs, clock it, update the model, sample after the edge.
   task automatic cycle(input bit wr, input logic [DBITS-1:0] d, input bit last,
                        input bit drop, input bit rd);
      i_wr = wr; i_wdata = d; i_wlast = last; i_wdrop = drop; i_rd = rd;
      @(posedge clk);
      model_apply(wr, d, last, drop, rd);
      #1;
      i_wr = 1'b0; i_wlast = 1'b0; i_wdrop = 1'b0; i_rd = 1'b0;
   endtask

   task automatic do_reset(input int n);
      i_rst = 1'b1;
      i_wr = 1'b0; i_wlast = 1'b0; i_wdrop = 1'b0; i_rd = 1'b0;
      repeat (n) @(posedge clk);
      m_c.delete(); m_p.delete(); m_err = 1'b0; m_ovf = 1'b0;
      #1;
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(2);
      n_tests++; if (o_rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b want 1", o_rempty); end
      n_tests++; if (o_wcount !== 3'd0) begin n_fail++; $display("FAIL reset_wcount: got %0d want 0", o_wcount); end
      n_tests++; if (o_wfull !== 1'b0) begin n_fail++; $display("FAIL reset_wfull: got %b want 0", o_wfull); end
      n_tests++; if (o_wafull !== 1'b0) begin n_fail++; $display("FAIL reset_wafull: got %b want 0", o_wafull); end
      n_tests++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o_ovf); end
      n_tests++; if (o_rlast !== 1'b0) begin n_fail++; $display("FAIL reset_rlast: got %b want 0", o_rlast); end
   endtask

   task automatic test_three_word();
      cycle(1, 73'h1, 0, 0, 0);
      n_tests++; if (o_rempty !== 1'b1) begin n_fail++; $display("FAIL p3_rempty_w1: got %b want 1", o_rempty); end
      cycle(1, 73'h2, 0, 0, 0);
      n_tests++; if (o_rempty !== 1'b1) begin n_fail++; $display("FAIL p3_rempty_w2: got %b want 1", o_rempty); end
      cycle(1, 73'h3, 1, 0, 0);
      n_tests++; if (o_rempty !== 1'b0) begin n_fail++; $display("FAIL p3_rempty_commit: got %b want 0", o_rempty); end
      n_tests++; if (o_wcount !== 3'd3) begin n_fail++; $display("FAIL p3_wcount: got %0d want 3", o_wcount); end
      n_tests++; if (o_wafull !== 1'b1) begin n_fail++; $display("FAIL p3_wafull: got %b want 1", o_wafull); end
      for (int i = 1; i <= 3; i++) begin
         n_tests++; if (o_rdata !== DBITS'(i)) begin n_fail++; $display("FAIL p3_rdata%0d: got %0h want %0h", i, o_rdata, i); end
         n_tests++; if (o_rlast !== (i == 3)) begin n_fail++; $display("FAIL p3_rlast%0d: got %b want %b", i, o_rlast, (i == 3)); end
         cycle(0, '0, 0, 0, 1);
      end
      n_tests++; if (o_rempty !== 1'b1) begin n_fail++; $display("FAIL p3_drained: got %b want 1", o_rempty); end
   endtask

   task automatic test_drop();
      cycle(1, 73'hB0, 0, 0, 0);
      cycle(1, 73'hB1, 0, 0, 0);
      n_tests++; if (o_wcount !== 3'd2) begin n_fail++; $display("FAIL drop_pre_wcount: got %0d want 2", o_wcount); end
      cycle(1, 73'hB2, 0, 1, 0);
      n_tests++; if (o_wcount !== 3'd0) begin n_fail++; $display("FAIL drop_wcount: got %0d want 0", o_wcount); end
      n_tests++; if (o_rempty !== 1'b1) begin n_fail++; $display("FAIL drop_rempty: got %b want 1", o_rempty); end
      n_tests++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL drop_ovf: got %b want 0", o_ovf); end
      cycle(1, 73'hA, 1, 0, 0);
      n_tests++; if (o_rdata !== 73'hA || o_rlast !== 1'b1 || o_rempty !== 1'b0) begin
         n_fail++; $display("FAIL drop_next_pkt: got data=%0h last=%b empty=%b want A/1/0", o_rdata, o_rlast, o_rempty); end
      cycle(0, '0, 0, 0, 1);
      n_tests++; if (o_rempty !== 1'b1) begin n_fail++; $display("FAIL drop_drained: got %b want 1", o_rempty); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) cycle(1, DBITS'(32'h50 + i), 0, 0, 0);
      n_tests++; if (o_wfull !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", o_wfull); end
      cycle(1, 73'h54, 1, 0, 0);
      n_tests++; if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", o_ovf); end
      n_tests++; if (o_wcount !== 3'd0) begin n_fail++; $display("FAIL ovf_wcount: got %0d want 0", o_wcount); end
      n_tests++; if (o_rempty !== 1'b1) begin n_fail++; $display("FAIL ovf_rempty: got %b want 1", o_rempty); end
      cycle(0, '0, 0, 0, 0);
      n_tests++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b want 0", o_ovf); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++) begin
         if (i > 0) begin
            n_tests++; if (o_rdata !== DBITS'(32'h100 + i - 1) || o_rlast !== 1'b1) begin
               n_fail++; $display("FAIL b2b_data%0d: got %0h/%b want %0h/1", i - 1, o_rdata, o_rlast, 32'h100 + i - 1); end
         end
         cycle(1, DBITS'(32'h100 + i), 1, 0, (i > 0));
         n_tests++; if (o_wfull !== 1'b0) begin n_fail++; $display("FAIL b2b_wfull%0d: got %b want 0", i, o_wfull); end
      end
      n_tests++; if (o_rdata !== 73'h113) begin n_fail++; $display("FAIL b2b_last_data: got %0h want 113", o_rdata); end
      cycle(0, '0, 0, 0, 1);
      n_tests++; if (o_rempty !== 1'b1 || o_wcount !== 3'd0) begin
         n_fail++; $display("FAIL b2b_drained: got empty=%b cnt=%0d want 1/0", o_rempty, o_wcount); end
   endtask

   task automatic test_reset_mid();
      cycle(1, 73'h21, 1, 0, 0);
      cycle(1, 73'h22, 1, 0, 0);
      cycle(1, 73'h23, 0, 0, 0);
      do_reset(1);
      n_tests++; if (o_rempty !== 1'b1) begin n_fail++; $display("FAIL rstmid_rempty: got %b want 1", o_rempty); end
      n_tests++; if (o_wcount !== 3'd0) begin n_fail++; $display("FAIL rstmid_wcount: got %0d want 0", o_wcount); end
      cycle(1, 73'h55, 1, 0, 0);
      n_tests++; if (o_rdata !== 73'h55 || o_rlast !== 1'b1 || o_wcount !== 3'd1) begin
         n_fail++; $display("FAIL rstmid_pkt: got %0h/%b cnt=%0d want 55/1/1", o_rdata, o_rlast, o_wcount); end
      cycle(0, '0, 0, 0, 1);
      n_tests++; if (o_rempty !== 1'b1) begin n_fail++; $display("FAIL rstmid_alone: got %b want 1", o_rempty); end
   endtask

   task automatic test_random();
      logic [DBITS-1:0] d;
      bit wr, last, drop, rd;
      for (int c = 0; c < 400; c++) begin
         n_tests++; if (o_rempty !== (m_c.size() == 0)) begin
            n_fail++; $display("FAIL rnd_rempty c%0d: got %b want %b", c, o_rempty, (m_c.size() == 0)); end
         n_tests++; if (o_wcount !== 3'(m_occ())) begin
            n_fail++; $display("FAIL rnd_wcount c%0d: got %0d want %0d", c, o_wcount, m_occ()); end
         n_tests++; if (o_wfull !== (m_occ() == int'(DEPTH)) || o_wafull !== (m_occ() >= int'(AFULL))) begin
            n_fail++; $display("FAIL rnd_flags c%0d: got full=%b afull=%b occ=%0d", c, o_wfull, o_wafull, m_occ()); end
         if (m_c.size() > 0) begin
            n_tests++; if (o_rdata !== m_c[0].data || o_rlast !== m_c[0].last) begin
               n_fail++; $display("FAIL rnd_head c%0d: got %0h/%b want %0h/%b", c, o_rdata, o_rlast, m_c[0].data, m_c[0].last); end
         end
         d    = DBITS'({$urandom(), $urandom(), $urandom()});
         wr   = ($urandom_range(0, 9) < 6);
         last = ($urandom_range(0, 9) < 3);
         drop = ($urandom_range(0, 19) == 0);
         rd   = ($urandom_range(0, 9) < (c % 100 < 50 ? 3 : 7));
         cycle(wr, d, last, drop, rd);
         n_tests++; if (o_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, o_ovf, m_ovf); end
      end
   endtask

   initial begin
      test_reset();
      test_three_word();
      test_drop();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pcie_req_pkt_fifo
